// File: rtl/prog_delay_line_pkg.sv
// Shared sizing and clamp helpers for the programmable delay line.
package prog_delay_line_pkg;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

   // Width of delay_cfg / delay_act: must hold MAX_DELAY itself.
   function automatic int dw_of(input int max_delay);
      return clog2(max_delay + 1);
   endfunction

   function automatic int ptr_w(input int max_delay);
      return (max_delay > 1) ? clog2(max_delay) : 1;
   endfunction

   function automatic int clamp_delay(input int cfg, input int max_delay);
      if (cfg == 0)
         return 1;
      else if (cfg > max_delay)
         return max_delay;
      else
         return cfg;
   endfunction

endpackage

// File: rtl/prog_delay_line_if.sv
// Sample/config bus of the delay line; master drives samples and config, slave returns delayed data.
interface prog_delay_line_if
   import prog_delay_line_pkg::*;
#(
   parameter int IN_W     = 10,
   parameter int OUT_W    = 16,
   parameter int CHANNELS = 2,
   parameter int DW       = dw_of(32)
);
   logic                      vld_in;
   logic [CHANNELS*IN_W-1:0]  din;
   logic [DW-1:0]             delay_cfg;
   logic                      cfg_load;
   logic [CHANNELS*OUT_W-1:0] dout;
   logic                      vld_out;
   logic                      primed;
   logic [DW-1:0]             delay_act;

   modport master (
      output vld_in, din, delay_cfg, cfg_load,
      input  dout, vld_out, primed, delay_act
   );

   modport slave (
      input  vld_in, din, delay_cfg, cfg_load,
      output dout, vld_out, primed, delay_act
   );
endinterface

// File: rtl/prog_delay_lane.sv
// One lane: sign-extend, circular history buffer, registered delayed output.
module prog_delay_lane
   import prog_delay_line_pkg::*;
#(
   parameter int IN_W      = 10,
   parameter int OUT_W     = 16,
   parameter int MAX_DELAY = 32,
   parameter int PW        = ptr_w(32)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_flush,
   input  logic             i_wr_en,
   input  logic             i_bypass,
   input  logic [PW-1:0]    i_wr_ptr,
   input  logic [PW-1:0]    i_rd_idx,
   input  logic [IN_W-1:0]  i_din,
   output logic [OUT_W-1:0] o_dout
);
   logic [OUT_W-1:0] r_mem [MAX_DELAY];
   logic [OUT_W-1:0] r_dout;
   logic [OUT_W-1:0] w_ext;

   assign w_ext  = OUT_W'($signed(i_din));
   assign o_dout = r_dout;

   // A flush zeroes history first; a coincident write then lands in the cleared buffer.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_DELAY; i++) r_mem[i] <= '0;
         r_dout <= '0;
      end else begin
         if (i_flush) begin
            for (int i = 0; i < MAX_DELAY; i++) r_mem[i] <= '0;
         end
         if (i_wr_en) begin
            r_mem[i_wr_ptr] <= w_ext;
            r_dout <= i_bypass ? w_ext : (i_flush ? '0 : r_mem[i_rd_idx]);
         end else if (i_flush) begin
            r_dout <= '0;
         end
      end
   end
endmodule

// File: rtl/prog_delay_line.sv
// Multi-lane programmable delay line: shared pointer, fill counter and delay control.
// One accept per clock, no backpressure; dout updates at the accepting edge.
module prog_delay_line
   import prog_delay_line_pkg::*;
#(
   parameter int IN_W          = 10,
   parameter int OUT_W         = 16,
   parameter int CHANNELS      = 2,
   parameter int MAX_DELAY     = 32,
   parameter int DEFAULT_DELAY = 17
) (
   input  logic            clk,
   input  logic            reset_n,
   prog_delay_line_if.slave bus
);
   localparam int DW = dw_of(MAX_DELAY);
   localparam int PW = ptr_w(MAX_DELAY);

   if (IN_W > OUT_W) begin : g_bad_width
      $error("prog_delay_line: IN_W must not exceed OUT_W");
   end
   if (MAX_DELAY < 1) begin : g_bad_max
      $error("prog_delay_line: MAX_DELAY must be at least 1");
   end
   if (DEFAULT_DELAY < 1 || DEFAULT_DELAY > MAX_DELAY) begin : g_bad_default
      $error("prog_delay_line: DEFAULT_DELAY out of range");
   end

   logic [PW-1:0]             r_wr_ptr;
   logic [DW-1:0]             r_count;
   logic [DW-1:0]             r_delay;
   logic                      r_primed;
   logic                      r_vld_out;

   logic [DW-1:0]             w_delay_nxt;
   logic [DW-1:0]             w_count_base;
   logic [DW-1:0]             w_count_nxt;
   logic                      w_primed_nxt;
   logic [PW-1:0]             w_ptr_nxt;
   logic [PW-1:0]             w_rd_idx;
   logic                      w_bypass;
   int                        w_rd_sum;
   logic [CHANNELS*OUT_W-1:0] w_dout;

   always_comb begin
      w_delay_nxt  = bus.cfg_load ? DW'(clamp_delay(int'(bus.delay_cfg), MAX_DELAY)) : r_delay;
      w_count_base = bus.cfg_load ? '0 : r_count;
      w_count_nxt  = w_count_base;
      if (bus.vld_in && (int'(w_count_base) < MAX_DELAY))
         w_count_nxt = w_count_base + DW'(1);
      w_primed_nxt = (w_count_nxt >= w_delay_nxt);

      w_ptr_nxt = (int'(r_wr_ptr) == MAX_DELAY - 1) ? '0 : r_wr_ptr + PW'(1);

      // Read slot holds the sample written D-1 accepts ago; the +MAX_DELAY keeps the sum positive.
      w_rd_sum = int'(r_wr_ptr) + MAX_DELAY + 1 - int'(w_delay_nxt);
      if (w_rd_sum >= MAX_DELAY)
         w_rd_sum = w_rd_sum - MAX_DELAY;
      w_rd_idx = PW'(w_rd_sum);
      w_bypass = (w_delay_nxt == DW'(1));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_count   <= '0;
         r_delay   <= DW'(DEFAULT_DELAY);
         r_primed  <= 1'b0;
         r_vld_out <= 1'b0;
      end else begin
         r_delay   <= w_delay_nxt;
         r_count   <= w_count_nxt;
         r_primed  <= w_primed_nxt;
         r_vld_out <= bus.vld_in && w_primed_nxt;
         if (bus.vld_in)
            r_wr_ptr <= w_ptr_nxt;
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
      prog_delay_lane #(
         .IN_W      (IN_W),
         .OUT_W     (OUT_W),
         .MAX_DELAY (MAX_DELAY),
         .PW        (PW)
      ) u_lane (
         .clk      (clk),
         .reset_n  (reset_n),
         .i_flush  (bus.cfg_load),
         .i_wr_en  (bus.vld_in),
         .i_bypass (w_bypass),
         .i_wr_ptr (r_wr_ptr),
         .i_rd_idx (w_rd_idx),
         .i_din    (bus.din[k*IN_W +: IN_W]),
         .o_dout   (w_dout[k*OUT_W +: OUT_W])
      );
   end

   assign bus.dout      = w_dout;
   assign bus.vld_out   = r_vld_out;
   assign bus.primed    = r_primed;
   assign bus.delay_act = r_delay;
endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: a sample-list model predicts each cycle's outputs.
module tb_prog_delay_line;
   import prog_delay_line_pkg::*;

   localparam int IN_W = 10;
   localparam int OUT_W = 16;
   localparam int CH = 2;
   localparam int MAXD = 32;
   localparam int DEFD = 17;
   localparam int DW = dw_of(MAXD);

   typedef struct packed {
      logic [CH*OUT_W-1:0] dout;
      logic                vld_out;
      logic                primed;
      logic [DW-1:0]       delay_act;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   exp_t                sb[$];
   logic [OUT_W-1:0]    h0[$];
   logic [OUT_W-1:0]    h1[$];
   int                  m_d = DEFD;
   logic [CH*OUT_W-1:0] m_dout = '0;

   always #5 clk = ~clk;

   prog_delay_line_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .DW(DW)) bus ();

   prog_delay_line #(
      .IN_W(IN_W), .OUT_W(OUT_W), .CHANNELS(CH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x);
      logic signed [IN_W-1:0]  s;
      logic signed [OUT_W-1:0] e;
      s = x;
      e = s;
      return e;
   endfunction

   // Drives one cycle: model predicts and pushes, DUT output is popped and compared #1 after the edge.
   task automatic step(input bit rst, input bit v, input logic [IN_W-1:0] d0, input logic [IN_W-1:0] d1,
                       input bit load, input int cfg, input string tag);
      exp_t e;
      int   len;
      if (!rst) begin
         h0.delete(); h1.delete();
         m_d = DEFD;
         m_dout = '0;
      end else begin
         if (load) begin
            h0.delete(); h1.delete();
            m_d = (cfg == 0) ? 1 : ((cfg > MAXD) ? MAXD : cfg);
            m_dout = '0;
         end
         if (v) begin
            h0.push_back(ext(d0));
            h1.push_back(ext(d1));
            len = h0.size();
            if (len >= m_d) m_dout = {h1[len-m_d], h0[len-m_d]};
            else            m_dout = '0;
         end
      end
      e.dout      = m_dout;
      e.primed    = rst && (h0.size() >= m_d);
      e.vld_out   = rst && v && e.primed;
      e.delay_act = DW'(m_d);
      sb.push_back(e);

      reset_n       = rst;
      bus.vld_in    = v;
      bus.din       = {d1, d0};
      bus.cfg_load  = load;
      bus.delay_cfg = DW'(cfg);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.dout !== e.dout) begin
         errors++;
         $display("FAIL %s dout: got %h expected %h", tag, bus.dout, e.dout);
      end
      checks++;
      if (bus.vld_out !== e.vld_out) begin
         errors++;
         $display("FAIL %s vld_out: got %b expected %b", tag, bus.vld_out, e.vld_out);
      end
      checks++;
      if (bus.primed !== e.primed) begin
         errors++;
         $display("FAIL %s primed: got %b expected %b", tag, bus.primed, e.primed);
      end
      checks++;
      if (bus.delay_act !== e.delay_act) begin
         errors++;
         $display("FAIL %s delay_act: got %0d expected %0d", tag, bus.delay_act, e.delay_act);
      end
      bus.vld_in   = 1'b0;
      bus.cfg_load = 1'b0;
   endtask

   task automatic test_reset();
      step(0, 1, 10'h155, 10'h0AA, 1, 5, "reset_dominates");
      step(0, 1, 10'h3FF, 10'h001, 1, 2, "reset_hold");
      checks++;
      if (bus.delay_act !== DW'(DEFD)) begin
         errors++;
         $display("FAIL reset_delay_act: got %0d expected %0d", bus.delay_act, DEFD);
      end
   endtask

   task automatic test_ramp();
      step(0, 0, '0, '0, 0, 0, "ramp_reset");
      for (int n = 1; n <= 40; n++) begin
         step(1, 1, IN_W'(n), '0, 0, 0, "ramp");
         if (n == 17) begin
            checks++;
            if (bus.dout[OUT_W-1:0] !== 16'd1 || bus.vld_out !== 1'b1) begin
               errors++;
               $display("FAIL ramp_first_primed: got dout=%h vld=%b expected dout=0001 vld=1",
                        bus.dout[OUT_W-1:0], bus.vld_out);
            end
         end
      end
      step(1, 0, 10'h3AB, 10'h111, 0, 0, "ramp_hold");
   endtask

   task automatic test_sign_ext();
      step(1, 0, '0, '0, 1, 3, "sx_load");
      for (int n = 0; n < 3; n++) step(1, 1, IN_W'(n + 7), 10'h200, 0, 0, "sx_neg");
      checks++;
      if (bus.dout[2*OUT_W-1:OUT_W] !== 16'hFE00) begin
         errors++;
         $display("FAIL sx_neg_lane1: got %h expected fe00", bus.dout[2*OUT_W-1:OUT_W]);
      end
      for (int n = 0; n < 3; n++) step(1, 1, 10'h300, 10'h1FF, 0, 0, "sx_pos");
      checks++;
      if (bus.dout[2*OUT_W-1:OUT_W] !== 16'h01FF || bus.dout[OUT_W-1:0] !== 16'hFF00) begin
         errors++;
         $display("FAIL sx_pos: got %h expected 01ffff00", bus.dout);
      end
   endtask

   task automatic test_sparse();
      step(1, 0, '0, '0, 1, 4, "sparse_load");
      for (int n = 1; n <= 12; n++) begin
         step(1, 1, IN_W'(n * 13), IN_W'($urandom_range(0, 1023)), 0, 0, "sparse_acc");
         step(1, 0, IN_W'($urandom_range(0, 1023)), IN_W'($urandom_range(0, 1023)), 0, 0, "sparse_idle");
         step(1, 0, IN_W'($urandom_range(0, 1023)), IN_W'($urandom_range(0, 1023)), 0, 0, "sparse_idle");
      end
   endtask

   task automatic test_clamp();
      step(1, 0, '0, '0, 1, 0, "clamp_zero");
      for (int n = 0; n < 3; n++)
         step(1, 1, IN_W'($urandom_range(0, 1023)), IN_W'($urandom_range(0, 1023)), 0, 0, "d1_bypass");
      step(1, 0, '0, '0, 1, 40, "clamp_high");
      for (int n = 0; n < 4; n++)
         step(1, 1, IN_W'($urandom_range(0, 1023)), IN_W'($urandom_range(0, 1023)), 0, 0, "d32_fill");
   endtask

   task automatic test_load_coincident();
      step(1, 0, '0, '0, 1, 8, "coin_load8");
      for (int n = 1; n <= 10; n++) step(1, 1, IN_W'(n + 100), IN_W'(n), 0, 0, "coin_prime");
      step(1, 1, 10'd5, 10'd9, 1, 3, "coin_load3");
      step(1, 1, 10'd6, 10'd0, 0, 0, "coin_after1");
      step(1, 1, 10'd7, 10'd0, 0, 0, "coin_after2");
      checks++;
      if (bus.dout[OUT_W-1:0] !== 16'd5 || bus.vld_out !== 1'b1) begin
         errors++;
         $display("FAIL coin_result: got dout=%h vld=%b expected dout=0005 vld=1",
                  bus.dout[OUT_W-1:0], bus.vld_out);
      end
   endtask

   task automatic test_wrap();
      step(1, 0, '0, '0, 1, 32, "wrap_load");
      for (int n = 1; n <= 100; n++) begin
         if (n == 50) step(0, 1, IN_W'(n), 10'h2AA, 1, 9, "wrap_reset");
         else         step(1, 1, IN_W'(n), IN_W'($urandom_range(0, 1023)), 0, 0, "wrap_acc");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.vld_in    = 1'b0;
      bus.din       = '0;
      bus.cfg_load  = 1'b0;
      bus.delay_cfg = '0;
      test_reset();
      test_ramp();
      test_sign_ext();
      test_sparse();
      test_clamp();
      test_load_coincident();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
